prog_seq_det: RTL and testbench
===============================

# prog_seq_det

Programmable serial bit-pattern detector. It is the parametrised successor of the fixed 5-state detector.
- Pattern and length (1..MAX_LEN) are loaded at run time.
- Overlapping or non-overlapping match mode is selectable.
- Input beats are qualified by a valid strobe.
- Matches are reported as a registered pulse and counted in a saturating counter.

It sits on a serial data stream, upstream of control logic that consumes `seq_found`.

## Interface
- `MAX_LEN`, 8, maximum pattern length in bits (≥2).
- `CNT_W`, 8, match counter width.
- `DEF_PATTERN`, 8'b0000_1011, pattern after reset, LSB-aligned, MAX_LEN bits.
- `DEF_LEN`, 4, pattern length after reset.
- `LEN_W`, $clog2(MAX_LEN)+1, derived, width of length fields.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  detector enable.
- `din_valid`  in  1  `din` carries a beat this cycle.
- `din`  in  1  serial data bit.
- `cfg_we`  in  1  load configuration this cycle.
- `cfg_pattern`  in  MAX_LEN  pattern; bit len-1 is the first bit received, bit 0 is the last.
- `cfg_len`  in  LEN_W  pattern length.
- `cfg_overlap`  in  1  1 = overlapping matches, 0 = non-overlapping.
- `clr_count`  in  1  synchronous clear of `match_count` (and `seq_seen`).
- `seq_found`  out  1  one-cycle match pulse, registered.
- `match_count`  out  CNT_W  saturating match count.
- `det_state`  out  2  FSM state: 0 = IDLE, 1 = FILL, 2 = HUNT.
- `seq_seen`  out  1  sticky match flag; present only with `PROG_SEQ_DET_STICKY_EN`.

## Operation
- **Accepted beat:** `en & din_valid & ~cfg_we`.
- **History:** `hist` is a MAX_LEN shift register. On each accepted beat, `hist <= {hist[MAX_LEN-2:0], din}`.
- **Fill counter:** counts accepted bits since the last clear, saturating at MAX_LEN.
- **Match:** on an accepted beat, with hist_next being the updated `hist` and fill_next the updated fill count: `fill_next ≥ len` and `hist_next[len-1:0] == pattern[len-1:0]`.
- **Length clamp on load:** `cfg_len` = 0 loads len = 1; `cfg_len` > MAX_LEN loads MAX_LEN.
- **Configuration load:** `cfg_we` latches pattern, len and overlap, and clears fill. `cfg_we` has priority over a coincident beat; that beat is dropped.
- **After a match:**
  - Overlap mode: fill keeps counting and stays saturated, so 10101 with pattern 101 gives 2 matches.
  - Non-overlap mode: fill is set to 0, so 10101 with pattern 101 gives 1 match.
- **FSM:**
  - IDLE → FILL when `en` = 1.
  - FILL → HUNT when fill_next ≥ len.
  - HUNT → FILL on a non-overlap match, or on `cfg_we`.
  - Any state → IDLE when `en` = 0. Fill clears; `hist` holds its value but is ignored.
- **match_count:** increments on each match and saturates at 2^CNT_W−1. `clr_count` wins over a coincident match, giving 0.
- **Unused pattern bits:** bits above len-1 are ignored.

## Timing
- **Reset values:**
  - `seq_found`, `match_count`, `seq_seen`, `hist` and fill = 0.
  - `det_state` = IDLE.
  - pattern = DEF_PATTERN, len = DEF_LEN, overlap = 1.
- **Match latency:** `seq_found` is high for exactly the one cycle after the clock edge that samples the completing beat.
  - `match_count` updates on that same edge.
  - Back-to-back overlapping matches give consecutive pulses.
- **Configuration timing:** the new configuration applies to the first beat accepted after the `cfg_we` edge.
- **Asynchronous reset:** `rst_n` low mid-sequence clears all state immediately. The first match after release needs a full len bits.
- **Gaps:** `din_valid` = 0 cycles do not shift history. Gaps of any length are transparent.

## Configuration
- **`PROG_SEQ_DET_STICKY_EN`:**
  - Defined: adds output `seq_seen`. It sets on the edge where a match occurs, holds, and is cleared only by `clr_count` or reset. Clear wins over a coincident match.
  - Undefined: the port and its flop are absent; all other behaviour is identical.

## Test plan
- **Defaults:** reset, `en` = 1, stream 1,0,1,1 → one `seq_found` pulse the cycle after the 4th beat; `match_count` = 1; `det_state` goes 0→1→2.
- **Overlap:** load pattern 3'b101, len 3, overlap = 1; stream 1,0,1,0,1 → pulses after beats 3 and 5; count = 2.
- **Non-overlap:** same load with overlap = 0 and the same stream → pulse after beat 3 only; count = 1.
- **Gaps and clamp:** valid gaps of 0–5 idle cycles inside the 1011 stream → same single pulse. `cfg_len` = 0 with pattern bit0 = 1 → every `din` = 1 beat pulses.
- **Saturation and clear:** CNT_W = 2; five matches → count stays 3. `clr_count` coincident with a match → count 0 (and `seq_seen` 0 if compiled in).
- **Mid-operation events:** `rst_n` low after 3 bits of 1011, then release and send 1 → no pulse. `cfg_we` coincident with the completing beat → no pulse; that beat is dropped.

Source files
------------

// File: rtl/prog_seq_det.sv
// Programmable serial bit-pattern detector with runtime pattern/length, overlap mode and saturating match count.
// Optional sticky match flag output seq_seen is compiled in with `define PROG_SEQ_DET_STICKY_EN.
module prog_seq_det #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1011),
  parameter int unsigned DEF_LEN = 4,
  localparam int unsigned LEN_W = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_count,
  output logic               seq_found,
  output logic [CNT_W-1:0]   match_count,
  output logic [1:0]         det_state
`ifdef PROG_SEQ_DET_STICKY_EN
  ,
  output logic               seq_seen
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HUNT = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] pattern;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_inc;
  logic [LEN_W-1:0]   fill_next;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   len_ld;
  logic               overlap;
  logic               beat;
  logic               match;

  // Beat qualification, history update and match evaluation against the updated history.
  always_comb begin
    beat      = en & din_valid & ~cfg_we;
    hist_next = (hist << 1) | MAX_LEN'(din);
    fill_inc  = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    len_mask  = ~({MAX_LEN{1'b1}} << len);
    match     = beat && (fill_inc >= len) &&
                ((hist_next & len_mask) == (pattern & len_mask));
    fill_next = fill;
    if (!en || cfg_we) begin
      fill_next = '0;
    end else if (beat) begin
      fill_next = (match && !overlap) ? '0 : fill_inc;
    end
  end

  // Requested length clamped into 1..MAX_LEN.
  always_comb begin
    len_ld = cfg_len;
    if (cfg_len == '0) begin
      len_ld = LEN_W'(1);
    end else if (cfg_len > LEN_W'(MAX_LEN)) begin
      len_ld = LEN_W'(MAX_LEN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!en) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_next = ST_FILL;
        ST_FILL: if (fill_next >= len) state_next = ST_HUNT;
        ST_HUNT: if (cfg_we || (match && !overlap)) state_next = ST_FILL;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    det_state = state;
  end

  // Configuration, history and fill tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern <= DEF_PATTERN;
      len     <= LEN_W'(DEF_LEN);
      overlap <= 1'b1;
      hist    <= '0;
      fill    <= '0;
    end else begin
      if (cfg_we) begin
        pattern <= cfg_pattern;
        len     <= len_ld;
        overlap <= cfg_overlap;
      end
      if (beat) begin
        hist <= hist_next;
      end
      fill <= fill_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_found   <= 1'b0;
      match_count <= '0;
    end else begin
      seq_found <= match;
      if (clr_count) begin
        match_count <= '0;
      end else if (match && (match_count != {CNT_W{1'b1}})) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

`ifdef PROG_SEQ_DET_STICKY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_seen <= 1'b0;
    end else if (clr_count) begin
      seq_seen <= 1'b0;
    end else if (match) begin
      seq_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_prog_seq_det.sv
// Randomized and directed bench for prog_seq_det against a queue-based reference model.
// A second instance with CNT_W = 2 shares the stimulus to exercise counter saturation.
module tb_prog_seq_det;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic               din_valid = 1'b0;
  logic               din = 1'b0;
  logic               cfg_we = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               clr_count = 1'b0;

  logic       seq_found, seq_found_s;
  logic [7:0] match_count;
  logic [1:0] match_count_s;
  logic [1:0] det_state, det_state_s;
`ifdef PROG_SEQ_DET_STICKY_EN
  logic       seq_seen, seq_seen_s;
`endif

  prog_seq_det u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din_valid(din_valid), .din(din),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clr_count(clr_count),
    .seq_found(seq_found), .match_count(match_count), .det_state(det_state)
`ifdef PROG_SEQ_DET_STICKY_EN
    , .seq_seen(seq_seen)
`endif
  );

  prog_seq_det #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .din_valid(din_valid), .din(din),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clr_count(clr_count),
    .seq_found(seq_found_s), .match_count(match_count_s), .det_state(det_state_s)
`ifdef PROG_SEQ_DET_STICKY_EN
    , .seq_seen(seq_seen_s)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: bits received since the fill was last cleared, oldest first.
  bit               q[$];
  logic [MAX_LEN-1:0] m_pat;
  int               m_len, m_ov, m_state, m_cnt, m_cnt2;
  bit               m_found, m_seen;
  int               n_chk = 0;
  int               n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pat = 8'b0000_1011;
    m_len = 4;
    m_ov = 1;
    m_state = 0;
    m_cnt = 0;
    m_cnt2 = 0;
    m_found = 1'b0;
    m_seen = 1'b0;
  endtask

  function automatic bit seq_hit();
    if (q.size() < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      if (q[q.size() - 1 - i] != m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit match;
    int ns;
    match = 1'b0;
    if (!en) begin
      q.delete();
      ns = 0;
    end else begin
      if (cfg_we) begin
        m_pat = cfg_pattern;
        m_len = (cfg_len == 0) ? 1 : ((cfg_len > MAX_LEN) ? MAX_LEN : int'(cfg_len));
        m_ov = int'(cfg_overlap);
        q.delete();
      end else if (din_valid) begin
        q.push_back(din);
        if (q.size() > MAX_LEN) void'(q.pop_front());
        match = seq_hit();
        if (match && m_ov == 0) q.delete();
      end
      case (m_state)
        0: ns = 1;
        1: ns = (q.size() >= m_len) ? 2 : 1;
        default: ns = (cfg_we || (match && m_ov == 0)) ? 1 : 2;
      endcase
    end
    m_state = ns;
    m_found = match;
    if (clr_count) begin
      m_cnt = 0;
      m_cnt2 = 0;
      m_seen = 1'b0;
    end else if (match) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
      m_seen = 1'b1;
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_found"}, seq_found, m_found);
    chk({tag, "_count"}, match_count, m_cnt);
    chk({tag, "_state"}, det_state, m_state);
    chk({tag, "_sat_count"}, match_count_s, m_cnt2);
    chk({tag, "_sat_found"}, seq_found_s, m_found);
`ifdef PROG_SEQ_DET_STICKY_EN
    chk({tag, "_seen"}, seq_seen, m_seen);
    chk({tag, "_sat_seen"}, seq_seen_s, m_seen);
`endif
  endtask

  // One clock: drive inputs, take the edge, update the model, compare away from the edge.
  task automatic cyc(input string tag, input bit e, input bit v, input bit d);
    en = e;
    din_valid = v;
    din = d;
    @(posedge clk);
    model_edge();
    #1;
    check_outs(tag);
    cfg_we = 1'b0;
    clr_count = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load(input string tag, input logic [7:0] pat, input logic [3:0] len, input bit ov);
    cfg_pattern = pat;
    cfg_len = len;
    cfg_overlap = ov;
    cfg_we = 1'b1;
    cyc(tag, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic send(input string tag, input logic [7:0] val, input int n, input int max_gap);
    logic [7:0] v;
    v = val;
    for (int i = n - 1; i >= 0; i--) begin
      for (int g = $urandom_range(max_gap, 0); g > 0; g--) cyc({tag, "_gap"}, 1'b1, 1'b0, 1'b0);
      cyc(tag, 1'b1, 1'b1, v[i]);
    end
  endtask

  initial begin
    do_reset();
    send("dflt", 8'b1011, 4, 0);
    load("ld_ov", 8'b101, 4'd3, 1'b1);
    send("ovl", 8'b10101, 5, 0);
    load("ld_nov", 8'b101, 4'd3, 1'b0);
    send("novl", 8'b10101, 5, 0);
    load("ld_gap", 8'b1011, 4'd4, 1'b1);
    send("gap", 8'b1011, 4, 5);
    send("gap2", 8'b1011, 4, 5);
    load("ld_clamp0", 8'h01, 4'd0, 1'b1);
    send("clamp0", 8'b1101_1111, 8, 0);
    clr_count = 1'b1;
    cyc("clr_hit", 1'b1, 1'b1, 1'b1);
    load("ld_clampmax", 8'hA5, 4'd15, 1'b0);
    send("clampmax", 8'hA5, 8, 1);
    cyc("idle", 1'b0, 1'b1, 1'b1);
    do_reset();
    send("mid_pre", 8'b101, 3, 0);
    do_reset();
    send("mid_post", 8'b1, 1, 0);
    send("mid_post2", 8'b1011, 4, 0);
    send("pre_cfg", 8'b101, 3, 0);
    cfg_pattern = 8'b1011;
    cfg_len = 4'd4;
    cfg_overlap = 1'b1;
    cfg_we = 1'b1;
    cyc("cfg_drop", 1'b1, 1'b1, 1'b1);
    send("post_cfg", 8'b1, 1, 0);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(149, 0) == 0) begin
        do_reset();
      end
      if ($urandom_range(19, 0) == 0) begin
        cfg_pattern = 8'($urandom);
        cfg_len = 4'($urandom_range(15, 0));
        cfg_overlap = 1'($urandom);
        cfg_we = 1'b1;
      end
      if ($urandom_range(29, 0) == 0) clr_count = 1'b1;
      cyc("rand", $urandom_range(15, 0) != 0, $urandom_range(3, 0) != 0, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
